// File: rtl/crf_pkg.sv
// Shared CRF definitions: AXI response codes, initiator FSM states, error codes
// and the default register offsets.
package crf_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_WR   = 4'd1,
      ST_WB   = 4'd2,
      ST_GAP  = 4'd3,
      ST_WIRQ = 4'd4,
      ST_RD   = 4'd5,
      ST_RR   = 4'd6,
      ST_DONE = 4'd7,
      ST_ERR  = 4'd8
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_BRESP   = 2'b01;
   localparam logic [1:0] ERR_RRESP   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [31:0] CRF_UPSTART_OFFSET = 32'h0000_0000;
   localparam logic [31:0] CRF_UPEND_OFFSET   = 32'h0000_0004;

   function automatic logic resp_ok(input logic [1:0] resp);
      return resp == RESP_OKAY;
   endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Drives AW and W valids for one write while active; each drops after its own
// handshake, and both_done flags the cycle in which the second one completes.
module axil_wr_join (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic awready,
   input  logic wready,
   output logic awvalid,
   output logic wvalid,
   output logic both_done
);

   logic aw_done;
   logic w_done;
   logic aw_hs;
   logic w_hs;

   assign awvalid   = active & ~aw_done;
   assign wvalid    = active & ~w_done;
   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   assign both_done = active & (aw_done | aw_hs) & (w_done | w_hs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (!active || both_done) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

endmodule

// File: rtl/crf_lite_initiator.sv
// AXI4-Lite master that writes UPSTART, then polls UPEND until the job ends.
// Define CRF_INIT_IRQ_WAIT_EN to wait on interrupt_updone instead of polling.
module crf_lite_initiator
   import crf_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] UPSTART_ADDR = AXI_ADDR_WIDTH'(CRF_UPSTART_OFFSET),
   parameter logic [AXI_ADDR_WIDTH-1:0] UPEND_ADDR   = AXI_ADDR_WIDTH'(CRF_UPEND_OFFSET),
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 2**20
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_start,
   output logic                        cmd_busy,
   output logic                        cmd_done,
   output logic                        cmd_err,
   output logic [1:0]                  err_code,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        interrupt_updone
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

`ifdef CRF_INIT_IRQ_WAIT_EN
   localparam state_e WAIT_ST = ST_WIRQ;
`else
   localparam state_e WAIT_ST = ST_GAP;
`endif

   state_e           state;
   state_e           state_n;
   logic [1:0]       code_n;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             tmo_hit;
   logic             in_wait;
   logic             wr_both;

   assign tmo_hit = (tmo_cnt == TMO_MAX);
   assign in_wait = (state == ST_GAP) || (state == ST_WIRQ) ||
                    (state == ST_RD)  || (state == ST_RR);

   axil_wr_join u_wr_join (
      .clk       (clk),
      .rst       (rst),
      .active    (state == ST_WR),
      .awready   (m_axi_awready),
      .wready    (m_axi_wready),
      .awvalid   (m_axi_awvalid),
      .wvalid    (m_axi_wvalid),
      .both_done (wr_both)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      code_n  = ERR_NONE;
      case (state)
         ST_IDLE: if (cmd_start) state_n = ST_WR;
         ST_WR:   if (wr_both) state_n = ST_WB;
         ST_WB: begin
            if (m_axi_bvalid) begin
               if (resp_ok(m_axi_bresp)) begin
                  state_n = WAIT_ST;
               end else begin
                  state_n = ST_ERR;
                  code_n  = ERR_BRESP;
               end
            end
         end
         ST_GAP: begin
            if (tmo_hit) begin
               state_n = ST_ERR;
               code_n  = ERR_TIMEOUT;
            end else if (gap_cnt == GAP_LAST) begin
               state_n = ST_RD;
            end
         end
`ifdef CRF_INIT_IRQ_WAIT_EN
         ST_WIRQ: begin
            if (tmo_hit) begin
               state_n = ST_ERR;
               code_n  = ERR_TIMEOUT;
            end else if (interrupt_updone) begin
               state_n = ST_RD;
            end
         end
`endif
         ST_RD: if (m_axi_arready) state_n = ST_RR;
         // A timeout seen while a read is in flight is reported only once R returns.
         ST_RR: begin
            if (m_axi_rvalid) begin
               if (!resp_ok(m_axi_rresp)) begin
                  state_n = ST_ERR;
                  code_n  = ERR_RRESP;
               end else if (tmo_hit) begin
                  state_n = ST_ERR;
                  code_n  = ERR_TIMEOUT;
               end else if (m_axi_rdata[0]) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = WAIT_ST;
               end
            end
         end
         ST_DONE: state_n = ST_IDLE;
         ST_ERR:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == ST_IDLE) begin
         tmo_cnt <= '0;
      end else if (in_wait && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (state == ST_GAP && gap_cnt != GAP_LAST) begin
         gap_cnt <= gap_cnt + 1'b1;
      end else begin
         gap_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_code <= ERR_NONE;
      end else if (state == ST_IDLE && cmd_start) begin
         err_code <= ERR_NONE;
      end else if (code_n != ERR_NONE) begin
         err_code <= code_n;
      end
   end

   assign cmd_busy = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
   assign cmd_done = (state == ST_DONE);
   assign cmd_err  = (state == ST_ERR);

   assign m_axi_awaddr  = UPSTART_ADDR;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wdata   = AXI_DATA_WIDTH'(1);
   assign m_axi_wstrb   = {(AXI_DATA_WIDTH/8){1'b1}};
   assign m_axi_bready  = (state == ST_WB);
   assign m_axi_arvalid = (state == ST_RD);
   assign m_axi_araddr  = UPEND_ADDR;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state == ST_RR);

   // Only bit0 of UPEND carries status.
   logic unused_rdata;
   assign unused_rdata = ^m_axi_rdata[AXI_DATA_WIDTH-1:1];
`ifndef CRF_INIT_IRQ_WAIT_EN
   logic unused_irq;
   assign unused_irq = interrupt_updone;
`endif

   a_awvalid_hold: assert property (@(posedge clk) disable iff (rst)
      m_axi_awvalid && !m_axi_awready |=> m_axi_awvalid);
   a_wvalid_hold: assert property (@(posedge clk) disable iff (rst)
      m_axi_wvalid && !m_axi_wready |=> m_axi_wvalid);
   a_arvalid_hold: assert property (@(posedge clk) disable iff (rst)
      m_axi_arvalid && !m_axi_arready |=> m_axi_arvalid);
   a_done_err_excl: assert property (@(posedge clk) disable iff (rst)
      !(cmd_done && cmd_err));

endmodule

// File: tb/tb_crf_lite_initiator.sv
// Directed bench for crf_lite_initiator: table of slave behaviours plus hand
// sequences for start filtering, reset mid-write and the interrupt wait mode.
module tb_crf_lite_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start, cmd_busy, cmd_done, cmd_err;
   logic [1:0]  err_code;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid, m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        interrupt_updone;

   always #5 clk = ~clk;

   crf_lite_initiator #(.POLL_GAP(16), .TIMEOUT(100)) dut (
      .clk(clk), .rst(rst),
      .cmd_start(cmd_start), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
      .cmd_err(cmd_err), .err_code(err_code),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .interrupt_updone(interrupt_updone)
   );

   typedef struct {
      int         aw_dly;
      int         w_dly;
      logic [1:0] bresp;
      logic [1:0] rresp;
      int         zeros;
      int         hold_idx;
      int         hold_len;
      int         exp_done;
      int         exp_code;
      int         exp_reads;
      int         exp_busy;
      int         exp_tail;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   int aw_dly, w_dly, zeros, hold_idx, hold_len;
   logic [1:0] b_cfg, r_cfg;
   int aw_wait, w_wait, ar_wait;
   bit aw_got, w_got, b_pend, r_pend;
   int n_aw, n_w, n_b, n_ar, n_r, stuck;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [2:0]  cap_awprot, cap_arprot;
   int cyc, r_hs_cyc, b_hs_cyc, done_cyc, end_cyc;
   int busy_cnt, done_cnt, err_cnt;
   logic start_req, start_on_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; stuck = 0;
      r_hs_cyc = -100; b_hs_cyc = -100; done_cyc = -100; end_cyc = -100;
      busy_cnt = 0; done_cnt = 0; err_cnt = 0;
      cap_awaddr = 'x; cap_wdata = 'x; cap_araddr = 'x; cap_wstrb = 'x;
      cap_awprot = 'x; cap_arprot = 'x;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
   endtask

   // One cycle of slave model and monitor, evaluated at the falling edge.
   task automatic step();
      @(negedge clk);
      cyc++;
      m_axi_rvalid = r_pend;
      m_axi_rresp  = r_cfg;
      m_axi_rdata  = (n_r == zeros) ? 32'h0000_0001 : 32'hFFFF_FFFE;
      if (r_pend && m_axi_rready) begin
         r_pend = 0; n_r++; r_hs_cyc = cyc;
      end
      m_axi_arready = m_axi_arvalid && (ar_wait >= ((n_ar == hold_idx) ? hold_len : 0));
      if (m_axi_arvalid && !m_axi_arready) ar_wait++;
      if (m_axi_arvalid && m_axi_arready) begin
         n_ar++; ar_wait = 0; r_pend = 1;
         cap_araddr = m_axi_araddr; cap_arprot = m_axi_arprot;
      end
      m_axi_bvalid = b_pend;
      m_axi_bresp  = b_cfg;
      if (b_pend && m_axi_bready) begin
         b_pend = 0; n_b++; b_hs_cyc = cyc;
      end
      if ((m_axi_awvalid && aw_got) || (m_axi_wvalid && w_got)) stuck++;
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
      if (m_axi_awvalid && !m_axi_awready) aw_wait++;
      if (m_axi_awvalid && m_axi_awready) begin
         n_aw++; aw_wait = 0; aw_got = 1;
         cap_awaddr = m_axi_awaddr; cap_awprot = m_axi_awprot;
      end
      m_axi_wready = m_axi_wvalid && (w_wait >= w_dly);
      if (m_axi_wvalid && !m_axi_wready) w_wait++;
      if (m_axi_wvalid && m_axi_wready) begin
         n_w++; w_wait = 0; w_got = 1;
         cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
      end
      if (aw_got && w_got) begin
         aw_got = 0; w_got = 0; b_pend = 1;
      end
      if (cmd_busy) busy_cnt++;
      if (cmd_done) begin done_cnt++; done_cyc = cyc; end_cyc = cyc; end
      if (cmd_err)  begin err_cnt++;  end_cyc = cyc; end
      cmd_start = start_req | (start_on_done & cmd_done);
   endtask

   task automatic wait_end(input string name);
      for (int i = 0; i < 400 && (done_cnt + err_cnt) == 0; i++) step();
      if ((done_cnt + err_cnt) == 0) begin
         n_chk++; n_fail++;
         $display("FAIL %s_wait: got no done/err expected one within 400 cycles", name);
      end
      repeat (4) step();
   endtask

   task automatic launch(input string name);
      start_req = 1; step();
      start_req = 0; step();
      chk({name, "_busy_on"}, 32'(cmd_busy), 32'd1);
      chk({name, "_code_clr"}, 32'(err_code), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      clear_model();
      aw_dly = v.aw_dly; w_dly = v.w_dly; b_cfg = v.bresp; r_cfg = v.rresp;
      zeros = v.zeros; hold_idx = v.hold_idx; hold_len = v.hold_len;
      launch(name);
      wait_end(name);
      chk({name, "_done"},  32'(done_cnt), 32'(v.exp_done));
      chk({name, "_err"},   32'(err_cnt), 32'(1 - v.exp_done));
      chk({name, "_code"},  32'(err_code), 32'(v.exp_code));
      chk({name, "_n_aw"},  32'(n_aw), 32'd1);
      chk({name, "_n_w"},   32'(n_w), 32'd1);
      chk({name, "_n_b"},   32'(n_b), 32'd1);
      chk({name, "_n_ar"},  32'(n_ar), 32'(v.exp_reads));
      chk({name, "_n_r"},   32'(n_r), 32'(v.exp_reads));
      chk({name, "_busy"},  32'(busy_cnt), 32'(v.exp_busy));
      chk({name, "_stuck"}, 32'(stuck), 32'd0);
      chk({name, "_awaddr"}, cap_awaddr, 32'h0);
      chk({name, "_wdata"},  cap_wdata, 32'h1);
      chk({name, "_wstrb"},  32'(cap_wstrb), 32'hF);
      chk({name, "_awprot"}, 32'(cap_awprot), 32'h0);
      if (v.exp_reads > 0) begin
         chk({name, "_araddr"}, cap_araddr, 32'h4);
         chk({name, "_arprot"}, 32'(cap_arprot), 32'h0);
      end
      if (v.exp_tail != 0) chk({name, "_tail"}, 32'(end_cyc - r_hs_cyc), 32'd1);
   endtask

   vec_t tbl[9];

   initial begin
      //            aw w  bresp  rresp  zeros hidx hlen done code reads busy tail
      tbl[0] = '{0, 0, 2'b00, 2'b00,    2,  -1,  0,   1,   0,   3,   56,  1};
      tbl[1] = '{0, 5, 2'b00, 2'b00,    0,  -1,  0,   1,   0,   1,   25,  1};
      tbl[2] = '{3, 0, 2'b00, 2'b00,    0,  -1,  0,   1,   0,   1,   23,  1};
      tbl[3] = '{2, 2, 2'b00, 2'b00,    0,  -1,  0,   1,   0,   1,   22,  1};
      tbl[4] = '{0, 0, 2'b10, 2'b00,    0,  -1,  0,   0,   1,   0,    2,  0};
      tbl[5] = '{0, 0, 2'b11, 2'b00,    0,  -1,  0,   0,   1,   0,    2,  0};
      tbl[6] = '{0, 0, 2'b00, 2'b10,    0,  -1,  0,   0,   2,   1,   20,  1};
      tbl[7] = '{0, 0, 2'b00, 2'b00, 1000,  -1,  0,   0,   3,   5,  103,  0};
      tbl[8] = '{0, 0, 2'b00, 2'b00, 1000,   4, 30,   0,   3,   5,  122,  1};

      cyc = 0; start_req = 0; start_on_done = 0; cmd_start = 0;
      interrupt_updone = 0;
      aw_dly = 0; w_dly = 0; zeros = 0; hold_idx = -1; hold_len = 0;
      b_cfg = 0; r_cfg = 0;
      clear_model();
      rst = 1;
      repeat (3) step();
      chk("rst_awvalid", 32'(m_axi_awvalid), 0);
      chk("rst_wvalid",  32'(m_axi_wvalid), 0);
      chk("rst_arvalid", 32'(m_axi_arvalid), 0);
      chk("rst_bready",  32'(m_axi_bready), 0);
      chk("rst_rready",  32'(m_axi_rready), 0);
      chk("rst_busy",    32'(cmd_busy), 0);
      chk("rst_done",    32'(cmd_done), 0);
      chk("rst_err",     32'(cmd_err), 0);
      chk("rst_code",    32'(err_code), 0);
      rst = 0;
      repeat (2) step();

`ifndef CRF_INIT_IRQ_WAIT_EN
      for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Start during busy and again in the done cycle must both be ignored.
      clear_model();
      aw_dly = 0; w_dly = 0; b_cfg = 0; r_cfg = 0; zeros = 0; hold_idx = -1;
      launch("seq5");
      repeat (8) step();
      start_req = 1; step(); start_req = 0;
      start_on_done = 1;
      wait_end("seq5");
      start_on_done = 0;
      repeat (30) step();
      chk("seq5_n_aw",  32'(n_aw), 1);
      chk("seq5_n_ar",  32'(n_ar), 1);
      chk("seq5_done",  32'(done_cnt), 1);
      chk("seq5_idle",  32'(cmd_busy), 0);
      chk("seq5_tail",  32'(done_cyc - r_hs_cyc), 1);

      // Second sequence with the interrupt held high: polling is unaffected.
      clear_model();
      zeros = 1; interrupt_updone = 1;
      launch("seq5b");
      wait_end("seq5b");
      interrupt_updone = 0;
      chk("seq5b_n_aw", 32'(n_aw), 1);
      chk("seq5b_n_ar", 32'(n_ar), 2);
      chk("seq5b_done", 32'(done_cnt), 1);
      chk("seq5b_busy", 32'(busy_cnt), 38);
`else
      clear_model();
      aw_dly = 0; w_dly = 0; b_cfg = 0; r_cfg = 0; zeros = 0; hold_idx = -1;
      launch("irq");
      for (int i = 0; i < 300 && (done_cnt + err_cnt) == 0; i++) begin
         step();
         if (n_b > 0 && cyc == b_hs_cyc + 50) begin
            chk("irq_no_early_read", 32'(n_ar), 0);
            interrupt_updone = 1;
         end
      end
      repeat (4) step();
      interrupt_updone = 0;
      chk("irq_done",  32'(done_cnt), 1);
      chk("irq_err",   32'(err_cnt), 0);
      chk("irq_n_ar",  32'(n_ar), 1);
      chk("irq_n_r",   32'(n_r), 1);
      chk("irq_tail",  32'(done_cyc - r_hs_cyc), 1);
`endif

      // Reset in the middle of a write drops every valid without a clock edge.
      clear_model();
      aw_dly = 0; w_dly = 50; zeros = 0; hold_idx = -1;
      start_req = 1; step(); start_req = 0;
      step(); step();
      chk("mid_wvalid_pre",  32'(m_axi_wvalid), 1);
      chk("mid_awvalid_pre", 32'(m_axi_awvalid), 0);
      #2 rst = 1;
      #1;
      chk("mid_wvalid_rst",  32'(m_axi_wvalid), 0);
      chk("mid_awvalid_rst", 32'(m_axi_awvalid), 0);
      chk("mid_busy_rst",    32'(cmd_busy), 0);
      repeat (2) step();
      rst = 0;
      step();
      run_vec(tbl[1], "recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/crf_lite_initiator.md
Name: crf_lite_initiator

Overview:
AXI4-Lite master that drives the config_register_file slave port from on-chip control logic in place of an external host. On a start command it writes UPSTART, then watches UPEND by polling reads until the upsample job finishes, and reports done or error. It sits between a local controller or testbench sequencer and the CRF lite slave, on the same clock as access_control.

Parameters:
AXI_DATA_WIDTH, 32, lite data width
AXI_ADDR_WIDTH, 32, lite address width
UPSTART_ADDR, 32'h0, CRF address of the UPSTART register
UPEND_ADDR, 32'h4, CRF address of the UPEND status register
POLL_GAP, 16, idle cycles between consecutive UPEND reads (>=1)
TIMEOUT, 2**20, maximum cycles spent in the wait phase before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_start  in  1  single-cycle start request; ignored unless idle
cmd_busy  out  1  high from start acceptance until done or error
cmd_done  out  1  one-cycle pulse on successful completion
cmd_err  out  1  one-cycle pulse on bad response or timeout
err_code  out  2  01 bresp!=OKAY, 10 rresp!=OKAY, 11 timeout; held until the next start
m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/AXI_ADDR_WIDTH/3  write address channel
m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/AXI_DATA_WIDTH/AXI_DATA_WIDTH/8  write data channel
m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/AXI_ADDR_WIDTH/3  read address channel
m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/AXI_DATA_WIDTH/2  read data channel
interrupt_updone  in  1  CRF completion interrupt, level

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: all valid signals 0, bready 0, rready 0, busy, done and err 0, err_code 0, FSM in IDLE, counters 0.
- awprot and arprot are fixed at 3'b000. wstrb is all ones. wdata is 1 (UPSTART bit0).
- FSM states and transitions:
  - IDLE: on cmd_start, go to WR and assert busy the next cycle.
  - WR: assert awvalid and wvalid together with awaddr=UPSTART_ADDR. Each valid drops independently after its own handshake (aw may complete before w, after it, or in the same cycle). Valids never drop before their handshake. Once both handshakes are complete, go to WB.
  - WB: bready=1. On bvalid, check bresp: OKAY goes to GAP; any other value goes to ERR with code 01.
  - GAP: count POLL_GAP cycles, then go to RD.
  - RD: assert arvalid with araddr=UPEND_ADDR until arready, then go to RR.
  - RR: rready=1. On rvalid, check rresp first: non-OKAY goes to ERR with code 10. Otherwise rdata[0]=1 goes to DONE and rdata[0]=0 goes back to GAP.
  - DONE: pulse done, clear busy, return to IDLE.
  - ERR: pulse err, clear busy, latch err_code, return to IDLE.
- Timeout counter:
  - Counts every cycle in GAP, RD and RR, and saturates.
  - When it reaches TIMEOUT while in GAP, go to ERR with code 11.
  - An outstanding AR or R is never abandoned: after a timeout hit in RD or RR, finish the transaction, then go to ERR with code 11.
- cmd_start while busy is ignored, with no queueing.
- Simultaneous done and start: the start is ignored. A new start is accepted from the IDLE cycle that follows.
- Latency with a zero-wait slave: cmd_start to first AW/W valid is 1 cycle. Done follows 1 cycle after the successful R handshake.
- Reset mid-transaction drops every valid immediately. The slave must also be reset; the block does not complete orphaned transactions.

Optional Feature:
CRF_INIT_IRQ_WAIT_EN
- Defined: after WB, the FSM enters WIRQ instead of GAP. On interrupt_updone=1 it performs exactly one confirming UPEND read (RD/RR):
  - rdata[0]=1 goes to DONE;
  - rdata[0]=0 returns to WIRQ.
  The timeout applies in WIRQ. POLL_GAP is unused.
- Undefined: polling only, and interrupt_updone is ignored.

Decomposition:
- Shared package crf_pkg holds:
  - the resp enum (OKAY, EXOKAY, SLVERR, DECERR);
  - the FSM state typedef;
  - the err_code constants;
  - the default UPSTART and UPEND offsets, also used by config_register_file.
- One sub-module, axil_wr_join, tracks the independent AW and W handshakes and flags "both done". Everything else lives in the top.

Test Plan:
1. Zero-wait slave, UPEND returns 0,0,1 → exactly one write (addr 0x0, data 1); three reads at 0x4 spaced by 16 idle cycles; done pulses once; busy lasts the whole sequence.
2. wready delayed 5 cycles after awready, and a second case with AW/W accepted in the same cycle → single write, no duplicate handshake, and awvalid drops the cycle after its own handshake.
3. Slave returns bresp=SLVERR → no reads issued; err pulses; err_code=01; busy=0.
4. TIMEOUT=100 with UPEND stuck at 0, and a second case with arready held low across the timeout → err with code 11; the last read still completes its R handshake first.
5. cmd_start pulsed during busy and again in the done cycle → both ignored; a later start runs a full second sequence.
6. CRF_INIT_IRQ_WAIT_EN, with interrupt_updone raised 50 cycles after the B handshake and UPEND=1 → exactly one read; done follows 1 cycle after the R handshake.
